mem_access_controller: RTL and testbench
========================================

MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

Interface
REQ-001 The block SHALL provide parameter TIMEOUT_CYCLES, default 15: the maximum number of cycles in ACCESS waiting for mem_ack.
REQ-002 The block SHALL provide the following ports:
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high.
- memRead_in, input, 1: the current MEM-stage instruction is a load.
- memWrite_in, input, 1: the current MEM-stage instruction is a store.
- addr_in, input, 32: access address.
- wdata_in, input, 32: store data.
- writebackEnable_in, input, 1: the instruction writes the register file.
- flush, input, 1: squash the current MEM-stage instruction.
- mem_req, output, 1: memory request.
- mem_we, output, 1: 1 = write, 0 = read.
- mem_addr, output, 32: memory address.
- mem_wdata, output, 32: memory write data.
- mem_ack, input, 1: memory completion, one-cycle pulse.
- mem_rdata, input, 32: read data, valid when mem_ack = 1.
- stall_out, output, 1: freeze PC and the IF/ID/EX/MEM registers.
- rdata_out, output, 32: load data toward the MEM/WB register.
- writebackEnable_out, output, 1: gated writeback enable toward the MEM/WB register.
- fault_out, output, 1: one-cycle timeout pulse.

Function
REQ-003 The block SHALL implement a state machine with the states IDLE, ACCESS, DONE and FAULT, with the state held in a register.
REQ-004 IDLE, when acc = (memRead_in | memWrite_in) & ~flush = 1:
- The block SHALL assert stall_out combinationally in the same cycle.
- At the clock edge it SHALL latch addr_in, wdata_in, memWrite_in and writebackEnable_in.
- It SHALL clear the wait counter and move to ACCESS.
REQ-005 IDLE, when acc = 0:
- The block SHALL hold stall_out = 0 and stay in IDLE.
- It SHALL drive writebackEnable_out = writebackEnable_in & ~flush combinationally.
- rdata_out SHALL hold its last value.
REQ-006 ACCESS outputs:
- mem_req = 1.
- mem_we, mem_addr and mem_wdata = the latched values, stable for the whole state.
- stall_out = 1 and writebackEnable_out = 0.
REQ-007 ACCESS when mem_ack = 1:
- The block SHALL register mem_rdata into rdata_out if the access is a read; rdata_out is unchanged on a write.
- It SHALL move to DONE.
REQ-008 ACCESS when mem_ack = 0:
- The wait counter SHALL increment.
- When the counter equals TIMEOUT_CYCLES-1, the block SHALL move to FAULT.
- If mem_ack and the timeout occur in the same cycle, the block SHALL take the ack path.
REQ-009 DONE outputs and transition:
- stall_out = 0 and mem_req = 0.
- writebackEnable_out = latched writebackEnable & ~squashed.
- The block SHALL move to IDLE unconditionally.
- Total load/store latency SHALL be ack-cycle + 1, and at least 3 cycles from the request being seen.
REQ-010 FAULT outputs and transition:
- fault_out = 1 for exactly one cycle, with stall_out = 0, mem_req = 0 and writebackEnable_out = 0.
- The block SHALL move to IDLE.
REQ-011 Flush during ACCESS:
- flush SHALL NOT drop mem_req; the handshake must complete.
- flush SHALL set a squashed flag, and the flag SHALL clear on entry to IDLE.
REQ-012 The block SHALL ignore mem_ack in IDLE, DONE and FAULT.
REQ-013 The block SHALL ignore new memRead_in/memWrite_in while in ACCESS, because the pipeline is frozen.
REQ-014 The block SHALL drive mem_req, mem_we, mem_addr and mem_wdata from registers only, with no combinational path from any input.
REQ-015 The wait counter SHALL be $clog2(TIMEOUT_CYCLES)+1 bits wide and SHALL saturate, never wrapping.

Reset
REQ-016 While reset = 1 at a clock edge, the block SHALL enter IDLE and clear the counter, the squashed flag and all latched values.
REQ-017 After reset the outputs SHALL be:
- mem_req, mem_we and fault_out = 0.
- mem_addr, mem_wdata and rdata_out = 32'h0.
- stall_out = 0; writebackEnable_out = 0 until the inputs drive it.
REQ-018 Reset asserted mid-ACCESS SHALL abandon the transaction, deasserting mem_req on the next edge.

Verification
REQ-019 The bench SHALL cover load with ack on the 2nd ACCESS cycle: memRead_in=1, addr 32'h100, mem_rdata 32'hDEADBEEF -> stall_out high 3 cycles, then DONE with rdata_out = 32'hDEADBEEF and writebackEnable_out = 1 for 1 cycle.
REQ-020 The bench SHALL cover store: memWrite_in=1, wdata 32'h12345678, ack on the 1st ACCESS cycle -> mem_we=1, mem_wdata=32'h12345678, rdata_out unchanged.
REQ-021 The bench SHALL cover timeout: no ack, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, fault_out pulses 1 cycle, writebackEnable_out=0, then IDLE.
REQ-022 The bench SHALL cover flush in ACCESS on cycle 1, ack on cycle 3 -> mem_req held until ack, and DONE gives writebackEnable_out=0.
REQ-023 The bench SHALL cover ALU passthrough: no mem op, writebackEnable_in=1, flush=0 -> stall_out=0 and writebackEnable_out=1 in the same cycle; with flush=1 -> writebackEnable_out=0.
REQ-024 The bench SHALL cover reset in the 2nd ACCESS cycle -> next cycle mem_req=0, state IDLE, a late mem_ack is ignored, and all outputs are at their reset values.

Source files
------------

// File: rtl/mem_access_controller.sv
// MEM-stage memory access controller: holds the pipeline while a load or store
// runs its request/acknowledge handshake, with a bounded wait and a fault pulse.
module mem_access_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        writebackEnable_in,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_out,
    output logic [31:0] rdata_out,
    output logic        writebackEnable_out,
    output logic        fault_out
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                squashed_q, squashed_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic                we_q,       we_d;
    logic                wben_q,     wben_d;
    logic [DATA_W-1:0]   rdata_q,    rdata_d;
    logic                mem_req_q,  mem_req_d;
    logic                fault_q,    fault_d;
    logic                acc_c;

    assign acc_c = (memRead_in | memWrite_in) & ~flush;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            squashed_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            wben_q     <= 1'b0;
            rdata_q    <= '0;
            mem_req_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            squashed_q <= squashed_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            wben_q     <= wben_d;
            rdata_q    <= rdata_d;
            mem_req_q  <= mem_req_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state, latching and pipeline-facing outputs.
    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        squashed_d          = squashed_q;
        addr_d              = addr_q;
        wdata_d             = wdata_q;
        we_d                = we_q;
        wben_d              = wben_q;
        rdata_d             = rdata_q;
        mem_req_d           = 1'b0;
        fault_d             = 1'b0;
        stall_out           = 1'b0;
        writebackEnable_out = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc_c) begin
                    // The instruction is held in MEM, so nothing reaches writeback yet.
                    stall_out  = 1'b1;
                    addr_d     = addr_in;
                    wdata_d    = wdata_in;
                    we_d       = memWrite_in;
                    wben_d     = writebackEnable_in;
                    cnt_d      = '0;
                    squashed_d = 1'b0;
                    mem_req_d  = 1'b1;
                    state_d    = ST_ACCESS;
                end else begin
                    writebackEnable_out = writebackEnable_in & ~flush;
                end
            end

            ST_ACCESS: begin
                stall_out = 1'b1;
                if (flush) begin
                    squashed_d = 1'b1;
                end
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else begin
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_LAST) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                writebackEnable_out = wben_q & ~squashed_q;
                squashed_d          = 1'b0;
                state_d             = ST_IDLE;
            end

            ST_FAULT: begin
                squashed_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata_out = rdata_q;
    assign fault_out = fault_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Randomized scoreboard bench for mem_access_controller with directed corner cases
// and a transaction-level reference model.
module tb_mem_access_controller;

    localparam int T = 4;

    logic        clk;
    logic        reset;
    logic        memRead_in;
    logic        memWrite_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        writebackEnable_in;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_out;
    logic [31:0] rdata_out;
    logic        writebackEnable_out;
    logic        fault_out;

    mem_access_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk                 (clk),
        .reset               (reset),
        .memRead_in          (memRead_in),
        .memWrite_in         (memWrite_in),
        .addr_in             (addr_in),
        .wdata_in            (wdata_in),
        .writebackEnable_in  (writebackEnable_in),
        .flush               (flush),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .stall_out           (stall_out),
        .rdata_out           (rdata_out),
        .writebackEnable_out (writebackEnable_out),
        .fault_out           (fault_out)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        wben;
        logic        fault;
        logic        abort;
        int          req_cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model_rdata = 32'h0;
    int          ack_delay = 0;
    logic [31:0] resp_data = 32'h0;
    bit          late_ack_pending = 0;
    bit          mon_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: got %s", name, what);
    endtask

    // Memory model: acks on the ack_delay-th request cycle (0 = never acks).
    initial begin
        int req_cnt;
        req_cnt   = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                req_cnt++;
                mem_ack   = (ack_delay != 0) && (req_cnt == ack_delay);
                mem_rdata = mem_ack ? resp_data : $urandom();
            end else begin
                req_cnt          = 0;
                mem_ack          = late_ack_pending;
                late_ack_pending = 0;
                mem_rdata        = $urandom();
            end
        end
    end

    // Monitor: checks request payload on mem_req rise and the outcome on its fall.
    initial begin
        exp_t e;
        bit   prev_req;
        bit   fault_follow;
        int   stall_run;
        int   req_run;
        prev_req     = 0;
        fault_follow = 0;
        stall_run    = 0;
        req_run      = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (fault_follow) begin
                chk("fault_one_cycle", 32'(fault_out), 32'(0));
                fault_follow = 0;
            end
            if (mem_req && !prev_req) begin
                req_run = 0;
                if (exp_q.size() == 0) fail_now("unexpected_req", "request with empty scoreboard");
                else begin
                    e = exp_q[0];
                    chk("req_we",    32'(mem_we), 32'(e.we));
                    chk("req_addr",  mem_addr,    e.addr);
                    chk("req_wdata", mem_wdata,   e.wdata);
                end
            end
            if (mem_req) req_run++;
            if (!mem_req && prev_req) begin
                if (exp_q.size() == 0) fail_now("unexpected_end", "completion with empty scoreboard");
                else begin
                    e = exp_q.pop_front();
                    chk("end_fault",      32'(fault_out),           32'(e.fault));
                    chk("req_cycles",     32'(req_run),             32'(e.req_cycles));
                    chk("stall_cycles",   32'(stall_run),           32'(e.req_cycles + 1));
                    chk("end_stall",      32'(stall_out),           32'(0));
                    chk("end_wben",       32'(writebackEnable_out), 32'(e.wben));
                    chk("end_rdata",      rdata_out,                e.rdata);
                    if (e.abort) begin
                        chk("abort_addr",  mem_addr,        32'h0);
                        chk("abort_wdata", mem_wdata,       32'h0);
                        chk("abort_we",    32'(mem_we),     32'(0));
                    end
                    if (e.fault) fault_follow = 1;
                end
            end
            if (stall_out) stall_run++;
            else stall_run = 0;
            prev_req = mem_req;
        end
    end

    task automatic drive_idle();
        memRead_in         = 1'b0;
        memWrite_in        = 1'b0;
        writebackEnable_in = 1'b0;
        flush              = 1'b0;
        addr_in            = 32'h0;
        wdata_in           = 32'h0;
    endtask

    // One full transaction; the expected outcome is derived from ack timing and flush alone.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wben, input int d, input int flush_cyc,
                          input logic [31:0] rdata);
        exp_t e;
        bit   complete;
        bit   flushed;
        int   rc;
        complete     = (d >= 1) && (d <= T);
        rc           = complete ? d : T;
        flushed      = (flush_cyc >= 1) && (flush_cyc <= rc);
        if (complete && !we) model_rdata = rdata;
        e.we         = we;
        e.addr       = addr;
        e.wdata      = wdata;
        e.rdata      = model_rdata;
        e.wben       = complete && wben && !flushed;
        e.fault      = !complete;
        e.abort      = 1'b0;
        e.req_cycles = rc;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        ack_delay          = d;
        resp_data          = rdata;
        memRead_in         = !we;
        memWrite_in        = we;
        addr_in            = addr;
        wdata_in           = wdata;
        writebackEnable_in = wben;
        flush              = 1'b0;
        @(negedge clk);
        chk("req_stall", 32'(stall_out), 32'(1));
        for (int i = 1; i <= T + 2; i++) begin
            @(posedge clk);
            #1;
            if (!mem_req) begin
                drive_idle();
                return;
            end
            // Frozen pipeline: new requests presented now must be ignored.
            memRead_in         = 1'($urandom());
            memWrite_in        = 1'($urandom());
            addr_in            = $urandom();
            wdata_in           = $urandom();
            writebackEnable_in = 1'($urandom());
            flush              = (i == flush_cyc);
        end
        fail_now("txn_bound", "mem_req still high after cycle budget");
        drive_idle();
    endtask

    task automatic idle_cycle(input logic w, input logic f);
        @(posedge clk);
        #1;
        writebackEnable_in = w;
        flush              = f;
        memRead_in         = f & 1'($urandom());
        memWrite_in        = f & 1'($urandom());
        addr_in            = $urandom();
        wdata_in           = $urandom();
        @(negedge clk);
        chk("pass_wben",  32'(writebackEnable_out), 32'(w & ~f));
        chk("pass_stall", 32'(stall_out),           32'(0));
    endtask

    task automatic reset_abort(input logic [31:0] addr);
        exp_t e;
        e.we         = 1'b0;
        e.addr       = addr;
        e.wdata      = 32'h0;
        e.rdata      = 32'h0;
        e.wben       = 1'b0;
        e.fault      = 1'b0;
        e.abort      = 1'b1;
        e.req_cycles = 2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        ack_delay          = 0;
        memRead_in         = 1'b1;
        addr_in            = addr;
        wdata_in           = 32'h0;
        writebackEnable_in = 1'b1;
        @(posedge clk);
        #1;
        drive_idle();
        @(posedge clk);
        #1;
        reset            = 1'b1;
        late_ack_pending = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        model_rdata = 32'h0;
        chk("late_ack_req",   32'(mem_req),   32'(0));
        chk("late_ack_stall", 32'(stall_out), 32'(0));
        chk("late_ack_fault", 32'(fault_out), 32'(0));
        chk("late_ack_rdata", rdata_out,      32'h0);
        chk("late_ack_addr",  mem_addr,       32'h0);
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req",   32'(mem_req),             32'(0));
        chk("rst_we",    32'(mem_we),              32'(0));
        chk("rst_fault", 32'(fault_out),           32'(0));
        chk("rst_addr",  mem_addr,                 32'h0);
        chk("rst_wdata", mem_wdata,                32'h0);
        chk("rst_rdata", rdata_out,                32'h0);
        chk("rst_stall", 32'(stall_out),           32'(0));
        chk("rst_wben",  32'(writebackEnable_out), 32'(0));
        mon_en = 1;

        // ALU passthrough, with and without flush.
        idle_cycle(1'b1, 1'b0);
        idle_cycle(1'b1, 1'b1);
        idle_cycle(1'b0, 1'b0);

        do_txn(1'b0, 32'h100, 32'h0, 1'b1, 2, 0, 32'hDEADBEEF);
        idle_cycle(1'b0, 1'b0);
        do_txn(1'b1, 32'h200, 32'h12345678, 1'b0, 1, 0, 32'hCAFEF00D);
        do_txn(1'b0, 32'h300, 32'h0, 1'b1, 0, 0, 32'h55555555);
        do_txn(1'b0, 32'h400, 32'h0, 1'b1, 3, 1, 32'hA5A5A5A5);
        do_txn(1'b0, 32'h500, 32'h0, 1'b1, 4, 0, 32'h0BADF00D);
        reset_abort(32'h600);

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle(1'($urandom()), 1'($urandom()));
            do_txn(1'($urandom()), $urandom(), $urandom(), 1'($urandom()),
                   $urandom_range(0, T + 1), $urandom_range(0, T), $urandom());
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
